// File: rtl/writeback_queue.sv
// Writeback queue: merges memory and ALU register writebacks into an in-order FIFO
// that drains one entry per cycle, with youngest-entry forwarding and per-register pending bits.
module writeback_queue #(
  parameter  int DATA_WIDTH = 64,
  parameter  int ADDR_WIDTH = 5,
  parameter  int DEPTH      = 4,
  localparam int REG_DEPTH  = 1 << ADDR_WIDTH,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memValid,
  input  logic [ADDR_WIDTH-1:0] memReg,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  memReady,
  input  logic                  aluValid,
  input  logic [ADDR_WIDTH-1:0] aluReg,
  input  logic [DATA_WIDTH-1:0] aluData,
  output logic                  aluReady,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] fwdRegA,
  input  logic [ADDR_WIDTH-1:0] fwdRegB,
  output logic                  fwdHitA,
  output logic                  fwdHitB,
  output logic [DATA_WIDTH-1:0] fwdDataA,
  output logic [DATA_WIDTH-1:0] fwdDataB,
  output logic [REG_DEPTH-1:0]  pending,
  output logic [CW-1:0]         count
);

  localparam logic [ADDR_WIDTH-1:0] ZREG = ADDR_WIDTH'(REG_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;

  logic [CW-1:0] w_free;
  logic          w_memZ, w_aluZ, w_memEnq, w_aluEnq;
  logic [PW-1:0] w_aluSlot;

  // Free space is taken from the registered count: this cycle's dequeue is not credited.
  assign w_free    = CW'(DEPTH) - r_count;
  assign w_memZ    = (memReg == ZREG);
  assign w_aluZ    = (aluReg == ZREG);
  assign memReady  = w_memZ | (w_free >= CW'(1));
  assign aluReady  = w_aluZ | ((memValid && !w_memZ) ? (w_free >= CW'(2)) : (w_free >= CW'(1)));
  assign w_memEnq  = memValid & memReady & ~w_memZ;
  assign w_aluEnq  = aluValid & aluReady & ~w_aluZ;
  assign w_aluSlot = r_tail + PW'(w_memEnq);

  assign write     = (r_count != '0);
  assign writeReg  = r_reg[r_head];
  assign writeData = r_data[r_head];
  assign count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (write) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      // Enqueued slots are always free slots, so they never collide with the dequeued head.
      if (w_memEnq) begin
        r_reg[r_tail]  <= memReg;
        r_data[r_tail] <= memData;
        r_vld[r_tail]  <= 1'b1;
      end
      if (w_aluEnq) begin
        r_reg[w_aluSlot]  <= aluReg;
        r_data[w_aluSlot] <= aluData;
        r_vld[w_aluSlot]  <= 1'b1;
      end
      r_tail  <= r_tail + PW'(w_memEnq) + PW'(w_aluEnq);
      r_count <= r_count + CW'(w_memEnq) + CW'(w_aluEnq) - CW'(write);
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwdHitA  = 1'b0;
    fwdHitB  = 1'b0;
    fwdDataA = '0;
    fwdDataB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[r_head + PW'(k)] && (r_reg[r_head + PW'(k)] == fwdRegA) && (fwdRegA != ZREG)) begin
        fwdHitA  = 1'b1;
        fwdDataA = r_data[r_head + PW'(k)];
      end
      if (r_vld[r_head + PW'(k)] && (r_reg[r_head + PW'(k)] == fwdRegB) && (fwdRegB != ZREG)) begin
        fwdHitB  = 1'b1;
        fwdDataB = r_data[r_head + PW'(k)];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i]) pending[r_reg[i]] = 1'b1;
    pending[REG_DEPTH-1] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the writeback rules.
module tb_writeback_queue;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam logic [AW-1:0] Z = 5'd31;

  logic          clk, rst;
  logic          memValid, aluValid, memReady, aluReady, write;
  logic [AW-1:0] memReg, aluReg, writeReg, fwdRegA, fwdRegB;
  logic [DW-1:0] memData, aluData, writeData, fwdDataA, fwdDataB;
  logic          fwdHitA, fwdHitB;
  logic [31:0]   pending;
  logic [2:0]    count;

  writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .write(write), .writeReg(writeReg), .writeData(writeData),
    .fwdRegA(fwdRegA), .fwdRegB(fwdRegB),
    .fwdHitA(fwdHitA), .fwdHitB(fwdHitB), .fwdDataA(fwdDataA), .fwdDataB(fwdDataB),
    .pending(pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } ent_t;
  ent_t q[$];

  int checks = 0;
  int failures = 0;
  logic s_memReady, s_aluReady;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Youngest pending value for a register, searched from the back of the model queue.
  task automatic lookup(input logic [AW-1:0] r, output bit hit, output logic [DW-1:0] d);
    hit = 0; d = '0;
    if (r != Z)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].r == r) begin hit = 1; d = q[i].d; break; end
  endtask

  task automatic step(input bit mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                      input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input logic [AW-1:0] fa, input logic [AW-1:0] fb);
    int fr;
    bit emr, ear, me, ae, ha, hb;
    logic [DW-1:0] da, db;
    logic [31:0] ep;
    @(negedge clk);
    memValid = mv; memReg = mr; memData = md;
    aluValid = av; aluReg = ar; aluData = ad;
    fwdRegA = fa; fwdRegB = fb;
    #1;
    fr  = D - q.size();
    emr = (mr == Z) || (fr >= 1);
    ear = (ar == Z) || ((mv && mr != Z) ? (fr >= 2) : (fr >= 1));
    chk("memReady", memReady, emr);
    chk("aluReady", aluReady, ear);
    chk("count", count, q.size());
    chk("write", write, q.size() != 0);
    if (q.size() != 0) begin
      chk("writeReg", writeReg, q[0].r);
      chk("writeData", writeData, q[0].d);
    end
    ep = '0;
    foreach (q[i]) ep[q[i].r] = 1'b1;
    ep[31] = 1'b0;
    chk("pending", pending, ep);
    lookup(fa, ha, da);
    lookup(fb, hb, db);
    chk("fwdHitA", fwdHitA, ha);
    chk("fwdDataA", fwdDataA, da);
    chk("fwdHitB", fwdHitB, hb);
    chk("fwdDataB", fwdDataB, db);
    s_memReady = memReady; s_aluReady = aluReady;
    me = mv && emr && (mr != Z);
    ae = av && ear && (ar != Z);
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (me) q.push_back('{mr, md});
    if (ae) q.push_back('{ar, ad});
  endtask

  task automatic idle(input logic [AW-1:0] fa);
    step(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, fa, 5'd0);
  endtask

  function automatic logic [AW-1:0] rreg();
    return ($urandom_range(0, 5) == 0) ? Z : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1;
    memValid = 0; memReg = 5'd7; memData = 64'h55;
    aluValid = 0; aluReg = 5'd7; aluData = 64'h66;
    fwdRegA = 0; fwdRegB = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_count", count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_memReady", memReady, 1);
    chk("rst_aluReady", aluReady, 1);
    chk("rst_fwdHitA", fwdHitA, 0);
    rst = 1'b0;

    // Single ALU writeback.
    step(0, 5'd0, 64'h0, 1, 5'd3, 64'hAA, 5'd3, 5'd0);
    idle(5'd3);
    chk("s1_writeReg", writeReg, 5'd3);
    chk("s1_writeData", writeData, 64'hAA);
    chk("s1_pending3", pending[3], 1);
    idle(5'd3);
    chk("s1_write_after", write, 0);

    // Same register from both ports: ALU is younger.
    step(1, 5'd5, 64'h1, 1, 5'd5, 64'h2, 5'd5, 5'd0);
    idle(5'd5);
    chk("s2_fwdDataA", fwdDataA, 64'h2);
    chk("s2_first", writeData, 64'h1);
    idle(5'd5);
    chk("s2_second", writeData, 64'h2);
    idle(5'd0);

    // Fill toward capacity: count reaches 3 with the head draining every cycle.
    step(1, 5'd1, 64'h11, 1, 5'd2, 64'h12, 5'd1, 5'd2);
    step(1, 5'd3, 64'h13, 1, 5'd4, 64'h14, 5'd2, 5'd4);
    step(1, 5'd6, 64'h15, 1, 5'd7, 64'h16, 5'd6, 5'd7);
    chk("s4_memReady", s_memReady, 1);
    chk("s4_aluReady", s_aluReady, 0);
    step(1, 5'd31, 64'h17, 1, 5'd31, 64'h18, 5'd31, 5'd6);
    chk("s3_z_memReady", s_memReady, 1);
    chk("s3_z_aluReady", s_aluReady, 1);
    repeat (4) idle(5'd0);

    // Zero-register write is discarded.
    step(0, 5'd0, 64'h0, 1, 5'd31, 64'hFF, 5'd31, 5'd31);
    idle(5'd31);
    chk("s5_write", write, 0);
    chk("s5_pending", pending, 0);

    // Reset with entries in flight.
    step(1, 5'd1, 64'h21, 1, 5'd2, 64'h22, 5'd0, 5'd0);
    step(1, 5'd3, 64'h23, 1, 5'd4, 64'h24, 5'd0, 5'd0);
    @(negedge clk);
    memValid = 0; aluValid = 0;
    #1;
    chk("s6_count_pre", count, 3);
    #1 rst = 1'b1;
    #1;
    chk("s6_count", count, 0);
    chk("s6_write", write, 0);
    chk("s6_pending", pending, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5'd1);
    idle(5'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, rreg(), {$urandom, $urandom},
           $urandom_range(0, 3) != 0, rreg(), {$urandom, $urandom},
           rreg(), rreg());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
